mul_feeder: RTL and testbench

MUL_FEEDER -- requirements
Module: mul_feeder

---
 rtl/mul_feeder.sv | 136 +++++++++++++
 tb/tb_mul_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mul_feeder.sv
// Operand digit feeder for a digit-serial GF(2^163) multiplier PE chain.
// Streams A, B and the reduction polynomial MSD-first, then idles while the chain drains.
module mul_feeder #(
   parameter int unsigned DIGITS    = 32,
   parameter int unsigned NUM_DIG   = 6,
   parameter int unsigned FLUSH_CYC = 12
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [162:0]      a,
   input  logic [162:0]      b,
   output logic              ready,
   output logic [DIGITS-1:0] a_out,
   output logic [DIGITS-1:0] b_out,
   output logic [DIGITS-1:0] g_out,
   output logic              ctr_out,
   output logic              dig_valid,
   output logic              done
);

   localparam int unsigned W    = DIGITS * NUM_DIG;
   // A zero-length flush still needs one cycle to carry the done pulse.
   localparam int unsigned FLEN = (FLUSH_CYC == 0) ? 1 : FLUSH_CYC;
   localparam int unsigned CW   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
   localparam int unsigned FW   = (FLEN > 1) ? $clog2(FLEN) : 1;
   localparam logic [W-1:0] G_PAD = W'(8'hC9);

   typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     dig_cnt_q, dig_cnt_d;
   logic [FW-1:0]     fl_cnt_q, fl_cnt_d;
   logic [W-1:0]      a_q, a_d, b_q, b_d;
   logic [W-1:0]      a_pad, b_pad;
   logic [DIGITS-1:0] a_out_d, b_out_d, g_out_d;
   logic              ready_d, ctr_out_d, dig_valid_d, done_d;

   assign a_pad = W'(a);
   assign b_pad = W'(b);

   function automatic logic [DIGITS-1:0] g_digit(input logic [CW-1:0] k);
      return DIGITS'(G_PAD >> (DIGITS * (NUM_DIG - 1 - 32'(k))));
   endfunction

   // Next state and next registered outputs; operands shift out MSD-first.
   always_comb begin
      state_d     = state_q;
      dig_cnt_d   = dig_cnt_q;
      fl_cnt_d    = fl_cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      a_out_d     = '0;
      b_out_d     = '0;
      g_out_d     = '0;
      ready_d     = 1'b0;
      ctr_out_d   = 1'b1;
      dig_valid_d = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (start && ready) begin
               state_d     = SEND;
               ready_d     = 1'b0;
               dig_cnt_d   = '0;
               a_d         = a_pad << DIGITS;
               b_d         = b_pad << DIGITS;
               a_out_d     = a_pad[W-1 -: DIGITS];
               b_out_d     = b_pad[W-1 -: DIGITS];
               g_out_d     = G_PAD[W-1 -: DIGITS];
               ctr_out_d   = 1'b0;
               dig_valid_d = 1'b1;
            end
         end
         SEND: begin
            if (dig_cnt_q == CW'(NUM_DIG - 1)) begin
               state_d  = FLUSH;
               fl_cnt_d = '0;
               done_d   = (FLEN == 1);
            end else begin
               dig_cnt_d   = dig_cnt_q + CW'(1);
               a_d         = a_q << DIGITS;
               b_d         = b_q << DIGITS;
               a_out_d     = a_q[W-1 -: DIGITS];
               b_out_d     = b_q[W-1 -: DIGITS];
               g_out_d     = g_digit(dig_cnt_q + CW'(1));
               dig_valid_d = 1'b1;
            end
         end
         FLUSH: begin
            if (fl_cnt_q == FW'(FLEN - 1)) begin
               state_d = IDLE;
               ready_d = 1'b1;
               a_d     = '0;
               b_d     = '0;
            end else begin
               fl_cnt_d = fl_cnt_q + FW'(1);
               done_d   = (fl_cnt_q == FW'(FLEN - 2));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         dig_cnt_q <= '0;
         fl_cnt_q  <= '0;
         a_q       <= '0;
         b_q       <= '0;
         a_out     <= '0;
         b_out     <= '0;
         g_out     <= '0;
         ready     <= 1'b0;
         ctr_out   <= 1'b1;
         dig_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         dig_cnt_q <= dig_cnt_d;
         fl_cnt_q  <= fl_cnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         a_out     <= a_out_d;
         b_out     <= b_out_d;
         g_out     <= g_out_d;
         ready     <= ready_d;
         ctr_out   <= ctr_out_d;
         dig_valid <= dig_valid_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_mul_feeder.sv
// Bench for mul_feeder: cycle-indexed frame model (cycles since accept) checked every clock.
module tb_mul_feeder;

   localparam int unsigned D  = 32;
   localparam int unsigned N  = 6;
   localparam int unsigned F  = 12;
   localparam int unsigned W  = D * N;
   localparam int unsigned FE = (F == 0) ? 1 : F;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic [162:0]  a = '0;
   logic [162:0]  b = '0;
   logic          ready, ctr_out, dig_valid, done;
   logic [D-1:0]  a_out, b_out, g_out;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: frame position k = cycles since the accept edge (0 = no frame)
   bit            m_act = 1'b0;
   int            m_k = 0;
   bit            m_rdy = 1'b0;
   logic [W-1:0]  m_a = '0;
   logic [W-1:0]  m_b = '0;
   logic [W-1:0]  m_g;

   mul_feeder #(.DIGITS(D), .NUM_DIG(N), .FLUSH_CYC(F)) dut (
      .clk(clk), .rstn(rstn), .start(start), .a(a), .b(b),
      .ready(ready), .a_out(a_out), .b_out(b_out), .g_out(g_out),
      .ctr_out(ctr_out), .dig_valid(dig_valid), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [D-1:0] dig(input logic [W-1:0] x, input int j);
      return D'(x >> (D * (N - 1 - j)));
   endfunction

   function automatic logic [162:0] rnd163();
      return 163'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_act = 1'b0;
      m_k   = 0;
      m_rdy = 1'b0;
   endtask

   task automatic check_all();
      bit v;
      v = m_act && (m_k <= int'(N));
      check("a_out",     64'(a_out),     v ? 64'(dig(m_a, m_k - 1)) : 64'h0);
      check("b_out",     64'(b_out),     v ? 64'(dig(m_b, m_k - 1)) : 64'h0);
      check("g_out",     64'(g_out),     v ? 64'(dig(m_g, m_k - 1)) : 64'h0);
      check("dig_valid", 64'(dig_valid), 64'(v));
      check("ctr_out",   64'(ctr_out),   64'(!(m_act && m_k == 1)));
      check("done",      64'(done),      64'(m_act && m_k == int'(N + FE)));
      check("ready",     64'(ready),     64'(m_rdy));
   endtask

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic step();
      @(posedge clk);
      #1;
      if (!rstn) begin
         m_reset();
      end else if (m_act) begin
         m_k++;
         if (m_k > int'(N + FE)) begin
            m_act = 1'b0;
            m_k   = 0;
         end
         m_rdy = !m_act;
      end else begin
         if (m_rdy && start) begin
            m_act = 1'b1;
            m_k   = 1;
            m_a   = W'(a);
            m_b   = W'(b);
         end
         m_rdy = !m_act;
      end
      check_all();
   endtask

   initial begin
      m_g = W'(8'hC9);
      m_reset();
      repeat (2) step();
      rstn = 1'b1;
      repeat (2) step();

      // Directed: a=1, b with bit 162 and bit 0 set
      a = 163'h1;
      b = (163'h4 << 160) | 163'h1;
      start = 1'b1;
      step();
      start = 1'b0;
      check("dir_b_dig0", 64'(b_out), 64'h4);
      check("dir_ctr_dig0", 64'(ctr_out), 64'h0);
      repeat (5) step();
      check("dir_g_dig5", 64'(g_out), 64'hC9);
      check("dir_a_dig5", 64'(a_out), 64'h1);
      repeat (15) step();

      // All-ones operand A
      a = '1;
      b = rnd163();
      start = 1'b1;
      step();
      start = 1'b0;
      check("ones_dig0", 64'(a_out), 64'h7);
      step();
      check("ones_dig1", 64'(a_out), 64'hFFFF_FFFF);
      repeat (20) step();

      // Start held high while operands keep changing: back-to-back frames, no re-capture
      start = 1'b1;
      repeat (45) begin
         a = rnd163();
         b = rnd163();
         step();
      end
      start = 1'b0;
      repeat (20) step();

      // Asynchronous reset in the middle of a frame
      a = rnd163();
      b = rnd163();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      rstn = 1'b0;
      #1;
      m_reset();
      check_all();
      repeat (2) step();
      rstn = 1'b1;
      start = 1'b1;
      repeat (3) step();
      start = 1'b0;
      repeat (20) step();

      // Random traffic
      repeat (600) begin
         start = ($urandom_range(0, 3) == 0);
         a = rnd163();
         b = rnd163();
         step();
      end
      start = 1'b0;
      repeat (20) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
